// File: rtl/operand_fetch.sv
// operand_fetch: single-entry operand fetch stage. It drives one-hot read
// selects to the register array and captures the returned bitlines on accept.
// It holds one instruction for downstream under a valid/ready handshake.
// Optional build macro: OPFETCH_BYPASS_EN. When it is defined, a write-back to
// a source register in the same cycle forwards wb_data into that operand.
module operand_fetch #(
   parameter int WIDTH = 16,
   parameter int NREG  = 16,
   localparam int RW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RW-1:0]    src1,
   input  logic [RW-1:0]    src2,
   input  logic [RW-1:0]    dst,
   input  logic             wb_en,
   input  logic [RW-1:0]    wb_reg,
   input  logic [WIDTH-1:0] wb_data,
   output logic [NREG-1:0]  ReadEnable1,
   output logic [NREG-1:0]  ReadEnable2,
   input  logic [WIDTH-1:0] Bitline1,
   input  logic [WIDTH-1:0] Bitline2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_op1,
   output logic [WIDTH-1:0] out_op2,
   output logic [RW-1:0]    out_dst
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] op1;
      logic [WIDTH-1:0] op2;
      logic [RW-1:0]    dst;
   } slot_t;

   localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

   state_t state, nstate;
   slot_t  slot, slot_nxt;
   logic   accept;

`ifdef OPFETCH_BYPASS_EN
   logic byp1, byp2;
   // Forward write-back data into each source port independently
   always_comb begin
      byp1 = wb_en && (wb_reg == src1);
      byp2 = wb_en && (wb_reg == src2);
      slot_nxt.op1 = byp1 ? wb_data : Bitline1;
      slot_nxt.op2 = byp2 ? wb_data : Bitline2;
      slot_nxt.dst = dst;
   end
`else
   // The write-back port is not used here. Upstream never reads a register
   // that is being written in the same cycle.
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_reg, wb_data};

   // Operands come straight from the register array bitlines
   always_comb begin
      slot_nxt.op1 = Bitline1;
      slot_nxt.op2 = Bitline2;
      slot_nxt.dst = dst;
   end
`endif

   // Handshake, read selects and next state. Flush overrides everything.
   // In reset the stage takes nothing, so the read selects stay quiet.
   always_comb begin
      in_ready    = rst && !flush && (state == EMPTY || out_ready);
      accept      = in_valid && in_ready;
      ReadEnable1 = '0;
      ReadEnable2 = '0;
      nstate      = state;
      if (accept) begin
         ReadEnable1 = ONE << src1;
         ReadEnable2 = ONE << src2;
      end
      if (flush)                          nstate = EMPTY;
      else if (accept)                    nstate = FULL;
      else if (state == FULL && out_ready) nstate = EMPTY;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= nstate;
   end

   // Capture the operands on accept. Otherwise keep the last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        slot <= '0;
      else if (accept) slot <= slot_nxt;
   end

   assign out_valid = (state == FULL);
   assign out_op1   = slot.op1;
   assign out_op2   = slot.op2;
   assign out_dst   = slot.dst;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors for operand_fetch against a small
// register-array model that answers the one-hot read selects.
module tb_operand_fetch;
   localparam int WIDTH = 16;
   localparam int NREG  = 16;

   logic             clk = 0;
   logic             rst = 0;
   logic             in_valid = 0, in_ready;
   logic [3:0]       src1 = 0, src2 = 0, dst = 0;
   logic             wb_en = 0;
   logic [3:0]       wb_reg = 0;
   logic [WIDTH-1:0] wb_data = 0;
   logic [NREG-1:0]  ReadEnable1, ReadEnable2;
   logic [WIDTH-1:0] Bitline1, Bitline2;
   logic             flush = 0;
   logic             out_valid, out_ready = 0;
   logic [WIDTH-1:0] out_op1, out_op2;
   logic [3:0]       out_dst;

   logic [WIDTH-1:0] regs [NREG];
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   // Register array model. A bitline reads as zero when nothing is selected.
   always_comb begin
      Bitline1 = '0;
      Bitline2 = '0;
      for (int i = 0; i < NREG; i++) begin
         if (ReadEnable1[i]) Bitline1 = Bitline1 | regs[i];
         if (ReadEnable2[i]) Bitline2 = Bitline2 | regs[i];
      end
   end

   operand_fetch #(.WIDTH(WIDTH), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src1(src1), .src2(src2), .dst(dst), .wb_en(wb_en), .wb_reg(wb_reg),
      .wb_data(wb_data), .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
      .Bitline1(Bitline1), .Bitline2(Bitline2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
      .out_op2(out_op2), .out_dst(out_dst));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d);
      in_valid = v; src1 = s1; src2 = s2; dst = d;
   endtask

   logic [WIDTH-1:0] e1, e2;
   logic [3:0] bs1 [4];
   logic [3:0] bs2 [4];

   initial begin
      for (int i = 0; i < NREG; i++) regs[i] = 16'h0;

      // Reset state
      in_valid = 1; src1 = 2; src2 = 6; out_ready = 1;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_op1", out_op1, 0);
      chk("rst_op2", out_op2, 0);
      chk("rst_dst", out_dst, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_re1", ReadEnable1, 0);
      chk("rst_re2", ReadEnable2, 0);
      in_valid = 0;
      @(negedge clk); rst = 1;

      // Basic accept
      regs[3] = 16'h1234; regs[5] = 16'hBEEF;
      step(); drive(1, 3, 5, 7); #1;
      chk("acc_ready", in_ready, 1);
      chk("acc_re1", ReadEnable1, 32'h0008);
      chk("acc_re2", ReadEnable2, 32'h0020);
      step(); drive(0, 0, 0, 0);
      chk("acc_valid", out_valid, 1);
      chk("acc_op1", out_op1, 16'h1234);
      chk("acc_op2", out_op2, 16'hBEEF);
      chk("acc_dst", out_dst, 7);

      // Downstream stalls for three cycles while a new instruction waits
      regs[1] = 16'h1111; regs[2] = 16'h2222;
      out_ready = 0; drive(1, 1, 2, 9);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_ready", in_ready, 0);
         chk("stall_re1", ReadEnable1, 0);
         chk("stall_re2", ReadEnable2, 0);
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_op1", out_op1, 16'h1234);
         chk("stall_dst", out_dst, 7);
      end
      out_ready = 1; #1;
      chk("unstall_ready", in_ready, 1);
      chk("unstall_re1", ReadEnable1, 32'h0002);
      step(); drive(0, 0, 0, 0);
      chk("unstall_valid", out_valid, 1);
      chk("unstall_op1", out_op1, 16'h1111);
      chk("unstall_op2", out_op2, 16'h2222);
      chk("unstall_dst", out_dst, 9);

      // Flush while full, with a new instruction offered
      out_ready = 0; flush = 1; drive(1, 3, 5, 1); #1;
      chk("flush_ready", in_ready, 0);
      chk("flush_re1", ReadEnable1, 0);
      chk("flush_re2", ReadEnable2, 0);
      step(); flush = 0; drive(0, 0, 0, 0); out_ready = 1;
      chk("flush_valid", out_valid, 0);
      chk("flush_keep_op1", out_op1, 16'h1111);

      // Same-cycle write-back to the register being read
      regs[4] = 16'h0000; regs[6] = 16'h6666;
      wb_en = 1; wb_reg = 4; wb_data = 16'hA5A5;
      drive(1, 4, 4, 3); #1;
      chk("same_re1", ReadEnable1, 32'h0010);
      chk("same_re2", ReadEnable2, 32'h0010);
`ifdef OPFETCH_BYPASS_EN
      e1 = 16'hA5A5; e2 = 16'hA5A5;
`else
      e1 = 16'h0000; e2 = 16'h0000;
`endif
      step(); drive(1, 6, 4, 5);
      chk("byp_op1", out_op1, e1);
      chk("byp_op2", out_op2, e2);
      // Only src2 matches the write-back register
`ifdef OPFETCH_BYPASS_EN
      e2 = 16'hA5A5;
`else
      e2 = 16'h0000;
`endif
      step(); drive(0, 0, 0, 0); wb_en = 0;
      chk("byp_ind_op1", out_op1, 16'h6666);
      chk("byp_ind_op2", out_op2, e2);
      chk("byp_ind_dst", out_dst, 5);

      // Asynchronous reset in the middle of a hold
      out_ready = 0; drive(1, 3, 5, 2);
      #2; rst = 0; #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_op1", out_op1, 0);
      chk("arst_op2", out_op2, 0);
      chk("arst_dst", out_dst, 0);
      chk("arst_ready", in_ready, 0);
      chk("arst_re1", ReadEnable1, 0);
      @(negedge clk); rst = 1; out_ready = 1;
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_op1", out_op1, 16'h1234);
      chk("post_rst_dst", out_dst, 2);
      drive(0, 0, 0, 0);
      step();
      chk("drain_valid", out_valid, 0);

      // Four back-to-back accepts
      bs1[0] = 0;  bs2[0] = 1;
      bs1[1] = 2;  bs2[1] = 3;
      bs1[2] = 8;  bs2[2] = 9;
      bs1[3] = 14; bs2[3] = 15;
      regs[0] = 16'h0A00; regs[1] = 16'h0B01; regs[2] = 16'h0A02; regs[3] = 16'h0B03;
      regs[8] = 16'h0A08; regs[9] = 16'h0B09; regs[14] = 16'h0A0E; regs[15] = 16'h0B0F;
      drive(1, bs1[0], bs2[0], 4'd10);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("b2b_valid", out_valid, 1);
         chk("b2b_op1", out_op1, {8'h0A, 4'h0, bs1[k]});
         chk("b2b_op2", out_op2, {8'h0B, 4'h0, bs2[k]});
         chk("b2b_dst", out_dst, 10 + k);
         if (k < 3) drive(1, bs1[k+1], bs2[k+1], 4'(11 + k));
         else       drive(0, 0, 0, 0);
      end
      step();
      chk("b2b_end_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the run always ends on its own.
   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WIDTH, 16, data width of register bitlines and operands.
REQ-002 Parameter NREG, 16, number of registers; register IDs are log2(NREG) = 4 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream presents a decoded instruction.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 src1, src2  input  4 each  source register IDs.
REQ-008 dst  input  4  destination register ID, passed through.
REQ-009 wb_en  input  1  write-back commits this cycle.
REQ-010 wb_reg  input  4  write-back register ID.
REQ-011 wb_data  input  WIDTH  write-back data.
REQ-012 ReadEnable1, ReadEnable2  output  NREG each  one-hot read-port selects to the register array.
REQ-013 Bitline1, Bitline2  input  WIDTH each  read data returned by the register array.
REQ-014 flush  input  1  discard held and incoming instruction.
REQ-015 out_valid  output  1  operands held for downstream.
REQ-016 out_ready  input  1  downstream accepts this cycle.
REQ-017 out_op1, out_op2  output  WIDTH each  captured operands.
REQ-018 out_dst  output  4  captured destination ID.

Function
REQ-019 Stage is a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 in_ready = !flush && (!out_valid || out_ready), combinational.
REQ-021 Accept = in_valid && in_ready; on accept, next state is FULL with operands captured at that edge (latency one cycle).
REQ-022 ReadEnable1 is one-hot at bit src1, and ReadEnable2 one-hot at bit src2, only during an accept cycle; otherwise both are all-zero so the bitlines float.
REQ-023 src1 == src2 drives the same bit on both ports; this is legal.
REQ-024 Without bypass, out_op1/out_op2 capture Bitline1/Bitline2 at the accept edge.
REQ-025 FULL && out_ready && !accept -> EMPTY; FULL && out_ready && accept -> FULL with the new data (back-to-back, no bubble).
REQ-026 FULL && !out_ready holds all outputs stable; in_ready=0; read enables all-zero.
REQ-027 flush -> next state EMPTY regardless of out_ready or in_valid; flush has priority over accept.
REQ-028 out_op1, out_op2 and out_dst are don't-care when out_valid=0 but retain their last captured value.

Reset
REQ-029 rst low asynchronously forces EMPTY, out_valid=0, out_op1=0, out_op2=0, out_dst=0.
REQ-030 While rst is low, ReadEnable1 and ReadEnable2 are all-zero and in_ready=0.
REQ-031 Reset asserted mid-hold discards the held instruction; the first accept after rst rises is a normal accept.

Configuration
REQ-032 Macro OPFETCH_BYPASS_EN.
REQ-033 Defined: on accept with wb_en=1 and wb_reg==src1, out_op1 captures wb_data instead of Bitline1; same rule for src2/out_op2, each independent.
REQ-034 Not defined: no bypass; operands always come from the bitlines, and upstream guarantees no same-cycle read of the register being written.

Verification
REQ-035 Reset, then in_valid=1, src1=3, src2=5, dst=7, out_ready=1, array R3=0x1234, R5=0xBEEF -> ReadEnable1=0x0008, ReadEnable2=0x0020 in the accept cycle; next cycle out_valid=1, out_op1=0x1234, out_op2=0xBEEF, out_dst=7.
REQ-036 FULL with out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, read enables 0x0000, outputs unchanged; out_ready=1 -> new instruction captured on the same edge.
REQ-037 OPFETCH_BYPASS_EN defined, accept src1=4, src2=4, with wb_en=1, wb_reg=4, wb_data=0xA5A5, stale R4=0x0000 -> out_op1=out_op2=0xA5A5; without the macro -> both 0x0000.
REQ-038 flush=1 with in_valid=1 while FULL -> in_ready=0, read enables 0x0000; next cycle out_valid=0.
REQ-039 rst pulsed low mid-cycle while FULL -> out_valid and all outputs 0 immediately, without waiting for a clock edge.
REQ-040 Four back-to-back accepts with out_ready=1 -> out_valid stays 1 for four consecutive cycles with no bubble and the operands appear in order.
